hazard_detect_unit: RTL and testbench

- Consumer side of the decode read-enable interface.
- Takes each decoded instruction's source registers, qualified by readEn1/readEn2, and checks them against a scoreboard of in-flight destination registers.
- Raises a stall so the ID stage holds and a bubble enters EX. Our 5-stage WISC pipeline has no forwarding.
- Sits beside the IF/ID and ID/EX pipeline registers; it feeds their write enables and the bubble mux.

---
 rtl/hazard_detect_unit_pkg.sv | 45 ++++
 rtl/hazard_detect_unit_if.sv | 52 +++++
 rtl/hazard_detect_unit_pend_stage.sv | 54 +++++
 rtl/hazard_detect_unit.sv | 123 ++++++++++++
 tb/tb_hazard_detect_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_detect_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_detect_unit_pkg
//   Shared types and constants for the WISC ID-stage hazard detector.
//   - reg_t / REG_R7   : architectural register index type and link register.
//   - OP_*             : 5-bit major opcodes (instr[15:11]). The hazard unit only
//                        consumes decoded read/write enables; these stay here so
//                        decoders and testbenches share one definition.
//   - stage_e          : scoreboard slot naming (0 = EX, 1 = MEM, 2 = WB).
//   - reg_match()      : valid-qualified register comparator used by each slot.
// -----------------------------------------------------------------------------
package hazard_detect_unit_pkg;

    localparam int REG_W = 3;
    typedef logic [REG_W-1:0] reg_t;

    // JAL/JALR write their return address here.
    localparam reg_t REG_R7 = 3'd7;

    // Major opcodes, instr[15:11].
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_ALU   = 5'b11011;

    typedef enum logic [1:0] {
        STG_EX  = 2'd0,
        STG_MEM = 2'd1,
        STG_WB  = 2'd2
    } stage_e;

    // A slot only matches when it holds a live producer.
    function automatic logic reg_match(input logic v, input reg_t r, input reg_t src);
        return v && (r == src);
    endfunction

endpackage

// File: rtl/hazard_detect_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_detect_unit_if
//   Decode-side bundle between the ID stage (master) and the hazard detector
//   (slave).
//
//   Handshake: id_valid qualifies every id_* field in the same cycle. stall is
//   the inverse of ready: the ID instruction is accepted (leaves ID and, if it
//   writes a register, enters the scoreboard) on a cycle where
//   id_valid & ~stall & ~flush. While stall is high the master must hold the
//   id_* fields stable. flush squashes the ID instruction unconditionally.
//
//   Signals:
//     id_valid, id_rs, id_rt, id_readEn1, id_readEn2, id_regWrite, id_writeReg,
//     flush                      master -> slave
//     stall, bubble, stall_cnt   slave  -> master
//     dbg_pend_v, dbg_pend_r     slave  -> observer (scoreboard contents,
//                                slot i at bit i / bits [3i+2:3i])
// -----------------------------------------------------------------------------
interface hazard_detect_unit_if
    import hazard_detect_unit_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 16
);

    logic                      id_valid;
    reg_t                      id_rs;
    reg_t                      id_rt;
    logic                      id_readEn1;
    logic                      id_readEn2;
    logic                      id_regWrite;
    reg_t                      id_writeReg;
    logic                      flush;
    logic                      stall;
    logic                      bubble;
    logic [CNT_W-1:0]          stall_cnt;
    logic [NUM_STAGES-1:0]     dbg_pend_v;
    logic [NUM_STAGES*REG_W-1:0] dbg_pend_r;

    modport master (
        output id_valid, id_rs, id_rt, id_readEn1, id_readEn2,
               id_regWrite, id_writeReg, flush,
        input  stall, bubble, stall_cnt, dbg_pend_v, dbg_pend_r
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_readEn1, id_readEn2,
               id_regWrite, id_writeReg, flush,
        output stall, bubble, stall_cnt, dbg_pend_v, dbg_pend_r
    );

endinterface

// File: rtl/hazard_detect_unit_pend_stage.sv
// -----------------------------------------------------------------------------
// pend_stage
//   One scoreboard slot: a valid bit plus a 3-bit destination register.
//   Loads unconditionally every cycle (load_v = 0 shifts in a bubble) and
//   clears synchronously on rst. Exposes source-register comparators so the
//   top only has to OR the slots it cares about.
//
//   Ports:
//     clk, rst         clock, synchronous active-high clear
//     load_v, load_r   entry arriving from the younger slot (or from ID)
//     rs, rt           ID-stage source registers to compare against
//     v, r             current slot contents
//     m_rs, m_rt       slot is valid and its register equals rs / rt
// -----------------------------------------------------------------------------
module pend_stage
    import hazard_detect_unit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_v,
    input  reg_t load_r,
    input  reg_t rs,
    input  reg_t rt,
    output logic v,
    output reg_t r,
    output logic m_rs,
    output logic m_rt
);

    logic v_d, v_q;
    reg_t r_d, r_q;

    // No freeze input exists: the slot advances every cycle.
    always_comb begin
        v_d = load_v;
        r_d = load_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            r_q <= '0;
        end else begin
            v_q <= v_d;
            r_q <= r_d;
        end
    end

    assign v    = v_q;
    assign r    = r_q;
    assign m_rs = reg_match(v_q, r_q, rs);
    assign m_rt = reg_match(v_q, r_q, rt);

endmodule

// File: rtl/hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// hazard_detect_unit
//   RAW hazard detector for the 5-stage WISC pipeline (no forwarding). Keeps a
//   shift-register scoreboard of in-flight destination registers (EX, MEM, WB)
//   and stalls the ID instruction while any enabled source operand matches a
//   live entry in the checked window. The scoreboard itself is the state; no
//   separate FSM is needed because hazards clear as producers shift out.
//
//   Parameters:
//     NUM_STAGES  in-flight stages tracked beyond ID
//     RF_BYPASS   1: register file forwards same-cycle writes, so the oldest
//                 (WB) slot is never checked
//     CNT_W       width of the saturating stall counter
//
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     hd          decode bundle (slave side): ID operands/enables and flush
//                 in; stall, bubble, stall_cnt and scoreboard debug out
// -----------------------------------------------------------------------------
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int RF_BYPASS  = 1,
    parameter int CNT_W      = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    hazard_detect_unit_if.slave   hd
);

    // Number of youngest slots that can still cause a hazard.
    localparam int NUM_CHK = (RF_BYPASS != 0) ? NUM_STAGES - 1 : NUM_STAGES;

    logic [NUM_STAGES-1:0] pend_v;
    logic [NUM_STAGES-1:0] m_rs;
    logic [NUM_STAGES-1:0] m_rt;
    reg_t                  pend_r [NUM_STAGES];

    logic push_v;
    logic hit_rs;
    logic hit_rt;
    logic hazard;
    logic stall;

    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // A stalled or squashed instruction does not leave ID, so it must not
    // be recorded as an in-flight producer.
    assign push_v = hd.id_valid & hd.id_regWrite & ~stall & ~hd.flush;

    generate
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
            logic ld_v;
            reg_t ld_r;
            if (g == 0) begin : g_head
                assign ld_v = push_v;
                assign ld_r = hd.id_writeReg;
            end else begin : g_tail
                assign ld_v = pend_v[g-1];
                assign ld_r = pend_r[g-1];
            end
            pend_stage u_stage (
                .clk    (clk),
                .rst    (rst),
                .load_v (ld_v),
                .load_r (ld_r),
                .rs     (hd.id_rs),
                .rt     (hd.id_rt),
                .v      (pend_v[g]),
                .r      (pend_r[g]),
                .m_rs   (m_rs[g]),
                .m_rt   (m_rt[g])
            );
        end
    endgenerate

    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i < NUM_CHK) begin
                hit_rs = hit_rs | m_rs[i];
                hit_rt = hit_rt | m_rt[i];
            end
        end
    end

    // readEn gating makes unused register fields (LBI, J, HALT, ...) inert;
    // flush wins over any hazard.
    always_comb begin
        hazard = hd.id_valid & ((hd.id_readEn1 & hit_rs) | (hd.id_readEn2 & hit_rt));
        stall  = hazard & ~hd.flush;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        hd.dbg_pend_r = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            hd.dbg_pend_r[i*REG_W +: REG_W] = pend_r[i];
        end
    end

    assign hd.stall      = stall;
    assign hd.bubble     = stall | hd.flush;
    assign hd.stall_cnt  = stall_cnt_q;
    assign hd.dbg_pend_v = pend_v;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_detect_unit
//   Two DUTs: u_dut (defaults: bypass on, 16-bit counter) and u_dut_nb
//   (no bypass, 4-bit counter so saturation is reachable quickly). Each step
//   drives one ID-stage instruction after a rising edge and samples
//   {stall, bubble, pend_v} at the falling edge against the expected queue.
// -----------------------------------------------------------------------------
module tb_hazard_detect_unit;
    import hazard_detect_unit_pkg::*;

    typedef struct packed {
        logic rst;
        logic valid;
        reg_t rs;
        reg_t rt;
        logic re1;
        logic re2;
        logic rw;
        reg_t wr;
        logic flush;
    } instr_t;

    logic clk;
    logic rst;

    hazard_detect_unit_if #(.NUM_STAGES(3), .CNT_W(16)) bus ();
    hazard_detect_unit_if #(.NUM_STAGES(3), .CNT_W(4))  bus_nb ();

    hazard_detect_unit #(.NUM_STAGES(3), .RF_BYPASS(1), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .hd  (bus)
    );

    hazard_detect_unit #(.NUM_STAGES(3), .RF_BYPASS(0), .CNT_W(4)) u_dut_nb (
        .clk (clk),
        .rst (rst),
        .hd  (bus_nb)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passes = 0;

    instr_t     stim_q [$];
    logic [4:0] exp_q  [$];   // {stall, bubble, pend_v[2:0]}

    function automatic instr_t mk(input logic v, input reg_t rs, input reg_t rt,
                                  input logic re1, input logic re2, input logic rw,
                                  input reg_t wr, input logic fl);
        instr_t t;
        t.rst   = 1'b0;
        t.valid = v;
        t.rs    = rs;
        t.rt    = rt;
        t.re1   = re1;
        t.re2   = re2;
        t.rw    = rw;
        t.wr    = wr;
        t.flush = fl;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_bus(input instr_t t);
        bus.id_valid    = t.valid;
        bus.id_rs       = t.rs;
        bus.id_rt       = t.rt;
        bus.id_readEn1  = t.re1;
        bus.id_readEn2  = t.re2;
        bus.id_regWrite = t.rw;
        bus.id_writeReg = t.wr;
        bus.flush       = t.flush;
    endtask

    task automatic set_bus_nb(input instr_t t);
        bus_nb.id_valid    = t.valid;
        bus_nb.id_rs       = t.rs;
        bus_nb.id_rt       = t.rt;
        bus_nb.id_readEn1  = t.re1;
        bus_nb.id_readEn2  = t.re2;
        bus_nb.id_regWrite = t.rw;
        bus_nb.id_writeReg = t.wr;
        bus_nb.flush       = t.flush;
    endtask

    task automatic drive(input logic sel, input instr_t t);
        instr_t idle;
        idle = mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        rst = t.rst;
        if (sel) begin
            set_bus_nb(t);
            set_bus(idle);
        end else begin
            set_bus(t);
            set_bus_nb(idle);
        end
    endtask

    // Queue one step with its expected response.
    task automatic plan(input instr_t t, input logic exp_stall, input logic [2:0] exp_pv);
        stim_q.push_back(t);
        exp_q.push_back({exp_stall, exp_stall | t.flush, exp_pv});
    endtask

    task automatic do_reset();
        stim_q.delete();
        exp_q.delete();
        drive(1'b0, mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        logic [4:0] got, ex;
        do_reset();
        checks++;
        if (bus.stall_cnt === 16'd0 && bus.dbg_pend_v === 3'b000 && bus.dbg_pend_r === 9'd0) passes++;
        else $display("FAIL reset_state: cnt=%h pend_v=%b pend_r=%h, required 0/000/000",
                      bus.stall_cnt, bus.dbg_pend_v, bus.dbg_pend_r);
        checks++;
        if (bus_nb.stall_cnt === 4'd0 && bus_nb.dbg_pend_v === 3'b000) passes++;
        else $display("FAIL reset_state_nb: cnt=%h pend_v=%b, required 0/000",
                      bus_nb.stall_cnt, bus_nb.dbg_pend_v);
        // Flushed reader/writer: bubble follows flush, nothing pushed.
        plan(mk(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1), 1'b0, 3'b000);
        plan(mk(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0), 1'b0, 3'b000);
        n = 0;
        while (stim_q.size() != 0) begin
            drive(1'b0, stim_q.pop_front());
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.dbg_pend_v};
            ex  = exp_q.pop_front();
            checks++;
            if (got === ex) passes++;
            else $display("FAIL reset step %0d: {stall,bubble,pend_v}=%b required %b", n, got, ex);
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_raw_bypass();
        int n;
        logic [4:0] got, ex;
        do_reset();
        plan(mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0), 1'b0, 3'b000); // ADDI R1,R2
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b1, 3'b001); // ADD R3,R1,R4
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b1, 3'b010);
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b0, 3'b100); // issues
        plan(mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, 3'b001);
        plan(mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, 3'b010);
        n = 0;
        while (stim_q.size() != 0) begin
            drive(1'b0, stim_q.pop_front());
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.dbg_pend_v};
            ex  = exp_q.pop_front();
            checks++;
            if (got === ex) passes++;
            else $display("FAIL raw_bypass step %0d: {stall,bubble,pend_v}=%b required %b", n, got, ex);
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.stall_cnt === 16'd2) passes++;
        else $display("FAIL raw_bypass_cnt: stall_cnt=%0d required 2", bus.stall_cnt);
    endtask

    task automatic test_raw_no_bypass();
        int n;
        logic [4:0] got, ex;
        do_reset();
        plan(mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0), 1'b0, 3'b000);
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b1, 3'b001);
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b1, 3'b010);
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b1, 3'b100);
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b0, 3'b000);
        plan(mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, 3'b001);
        n = 0;
        while (stim_q.size() != 0) begin
            drive(1'b1, stim_q.pop_front());
            @(negedge clk);
            got = {bus_nb.stall, bus_nb.bubble, bus_nb.dbg_pend_v};
            ex  = exp_q.pop_front();
            checks++;
            if (got === ex) passes++;
            else $display("FAIL raw_no_bypass step %0d: {stall,bubble,pend_v}=%b required %b", n, got, ex);
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus_nb.stall_cnt === 4'd3) passes++;
        else $display("FAIL raw_no_bypass_cnt: stall_cnt=%0d required 3", bus_nb.stall_cnt);
    endtask

    task automatic test_readen_gating();
        int n;
        logic [4:0] got, ex;
        do_reset();
        plan(mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0), 1'b0, 3'b000); // ADDI R1
        plan(mk(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0), 1'b0, 3'b001); // LBI R1,#7
        plan(mk(1'b0, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0), 1'b0, 3'b011); // ID bubble
        plan(mk(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, 3'b110); // J
        n = 0;
        while (stim_q.size() != 0) begin
            drive(1'b0, stim_q.pop_front());
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.dbg_pend_v};
            ex  = exp_q.pop_front();
            checks++;
            if (got === ex) passes++;
            else $display("FAIL readen_gating step %0d: {stall,bubble,pend_v}=%b required %b", n, got, ex);
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.stall_cnt === 16'd0) passes++;
        else $display("FAIL readen_gating_cnt: stall_cnt=%0d required 0", bus.stall_cnt);
    endtask

    task automatic test_flush();
        int n;
        logic [4:0] got, ex;
        do_reset();
        plan(mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0), 1'b0, 3'b000); // ADDI R5
        plan(mk(1'b1, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1), 1'b0, 3'b001); // BEQZ R5, flushed
        plan(mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1), 1'b0, 3'b010); // squashed writer R6
        plan(mk(1'b1, 3'd6, 3'd6, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0), 1'b0, 3'b100); // reader R6
        n = 0;
        while (stim_q.size() != 0) begin
            drive(1'b0, stim_q.pop_front());
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.dbg_pend_v};
            ex  = exp_q.pop_front();
            checks++;
            if (got === ex) passes++;
            else $display("FAIL flush step %0d: {stall,bubble,pend_v}=%b required %b", n, got, ex);
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_store_rt();
        int n;
        logic [4:0] got, ex;
        do_reset();
        plan(mk(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0), 1'b0, 3'b000); // ADD R6
        plan(mk(1'b1, 3'd2, 3'd6, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0), 1'b1, 3'b001); // ST R2,R6
        plan(mk(1'b1, 3'd2, 3'd6, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0), 1'b1, 3'b010);
        plan(mk(1'b1, 3'd2, 3'd6, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0), 1'b0, 3'b100);
        plan(mk(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b0, 3'b000); // ADD R3
        plan(mk(1'b1, 3'd2, 3'd6, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0), 1'b0, 3'b001); // ST R2,R6
        n = 0;
        while (stim_q.size() != 0) begin
            drive(1'b0, stim_q.pop_front());
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.dbg_pend_v};
            ex  = exp_q.pop_front();
            checks++;
            if (got === ex) passes++;
            else $display("FAIL store_rt step %0d: {stall,bubble,pend_v}=%b required %b", n, got, ex);
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [4:0] got, ex;
        do_reset();
        plan(mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0), 1'b0, 3'b000); // ADDI R1
        plan(mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0), 1'b0, 3'b001); // ADDI R1
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b1, 3'b011); // ADD R3,R1
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b1, 3'b110);
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b0, 3'b100);
        plan(mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0), 1'b0, 3'b001); // ADDI R0
        plan(mk(1'b1, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), 1'b1, 3'b011); // reads R0
        plan(mk(1'b1, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), 1'b1, 3'b110);
        plan(mk(1'b1, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, 3'b100);
        n = 0;
        while (stim_q.size() != 0) begin
            drive(1'b0, stim_q.pop_front());
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.dbg_pend_v};
            ex  = exp_q.pop_front();
            checks++;
            if (got === ex) passes++;
            else $display("FAIL back_to_back step %0d: {stall,bubble,pend_v}=%b required %b", n, got, ex);
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.stall_cnt === 16'd4) passes++;
        else $display("FAIL back_to_back_cnt: stall_cnt=%0d required 4", bus.stall_cnt);
    endtask

    task automatic test_reset_mid_stall();
        int n;
        logic [4:0] got, ex;
        instr_t t;
        do_reset();
        plan(mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0), 1'b0, 3'b000);
        t = mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0);
        t.rst = 1'b1;
        plan(t, 1'b1, 3'b001);
        plan(mk(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0), 1'b0, 3'b000);
        plan(mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, 3'b001);
        n = 0;
        while (stim_q.size() != 0) begin
            drive(1'b0, stim_q.pop_front());
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.dbg_pend_v};
            ex  = exp_q.pop_front();
            checks++;
            if (got === ex) passes++;
            else $display("FAIL reset_mid_stall step %0d: {stall,bubble,pend_v}=%b required %b", n, got, ex);
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.stall_cnt === 16'd0) passes++;
        else $display("FAIL reset_mid_stall_cnt: stall_cnt=%0d required 0", bus.stall_cnt);
    endtask

    task automatic test_saturation();
        int n;
        int exp_cnt;
        logic [4:0] got, ex;
        reg_t r;
        do_reset();
        n = 0;
        for (int rep = 0; rep < 6; rep++) begin
            r = 3'($urandom_range(0, 7));
            plan(mk(1'b1, ~r, 3'd0, 1'b0, 1'b0, 1'b1, r, 1'b0), 1'b0, 3'b000);
            for (int k = 0; k < 3; k++) begin
                plan(mk(1'b1, r, 3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0, 3'd0, 1'b0),
                     1'b1, 3'(1 << k));
            end
            plan(mk(1'b1, r, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, 3'b000);
            while (stim_q.size() != 0) begin
                drive(1'b1, stim_q.pop_front());
                @(negedge clk);
                got = {bus_nb.stall, bus_nb.bubble, bus_nb.dbg_pend_v};
                ex  = exp_q.pop_front();
                checks++;
                if (got === ex) passes++;
                else $display("FAIL saturation step %0d: {stall,bubble,pend_v}=%b required %b", n, got, ex);
                n++;
                @(posedge clk);
                #1;
            end
            exp_cnt = (3 * (rep + 1) > 15) ? 15 : 3 * (rep + 1);
            checks++;
            if (bus_nb.stall_cnt === 4'(exp_cnt)) passes++;
            else $display("FAIL saturation_cnt rep %0d: stall_cnt=%0d required %0d",
                          rep, bus_nb.stall_cnt, exp_cnt);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        test_reset();
        test_raw_bypass();
        test_raw_no_bypass();
        test_readen_gating();
        test_flush();
        test_store_rt();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
